uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
// - Serial-to-parallel half of the memory-mapped UART: 8N1 receive, 16x oversampled, LSB first.
// - Feeds the UART register block: data at UART_REG_DATA, flags at UART_REG_STATUS.
// - FSM uses the uart_fsm_state_t RX encodings: S_UART_RX_IDLE, S_UART_RX_VALIDATE_START,
//   S_UART_RX_READ_DATA, S_UART_RX_STOP.
// PARAMETERS
// - CLK_FREQ_HZ  20_000_000  system clock frequency
// - BAUD_RATE    115_200     serial bit rate
// - OVERSAMPLE   16          sample ticks per bit
// - Derived TICK_DIV = CLK_FREQ_HZ / (BAUD_RATE*OVERSAMPLE), truncated. Must be >= 1 (elaboration $error otherwise).
// PORTS
// - clk            in   1   system clock, rising edge
// - reset_n        in   1   asynchronous, active-low reset
// - rx_serial_in   in   1   asynchronous serial line, idle high
// - rx_data        out  8   last good received byte
// - rx_data_ready  out  1   sticky: unread byte held in rx_data
// - rx_data_ack    in   1   1-cycle strobe from register block on DATA read; clears rx_data_ready
// - rx_busy        out  1   high in any state other than S_UART_RX_IDLE
// - frame_error    out  1   sticky: stop bit sampled low
// - overrun_error  out  1   sticky: byte completed while rx_data_ready=1
// - err_clear      in   1   1-cycle strobe; clears frame_error, overrun_error (and parity_error)
// BEHAVIOUR
// - Reset: synchronizer FFs=1, FSM=IDLE, all counters 0, all outputs 0. Reset mid-frame aborts the frame; no partial data.
// - rx_serial_in passes a 2-FF synchronizer; the edge detector keeps the previous synchronized value.
// - Tick gen: counter 0..TICK_DIV-1, 1-cycle tick at wrap; free-running. Sample counter advances on ticks only.
// - IDLE: falling edge on synced line (prev=1, cur=0) -> VALIDATE_START; sample_cnt=0.
//   A line held low does not retrigger.
// - VALIDATE_START: on the tick where sample_cnt==7 (mid-bit), sample the line.
//   Low -> READ_DATA, sample_cnt=0, bit_idx=0. High -> IDLE (glitch rejected, no flags).
// - READ_DATA: sample on the tick where sample_cnt==15 (one bit after mid-start), shift into shift_reg[7] (right shift, LSB first).
//   Then sample_cnt=0 and bit_idx++. After bit_idx reaches 8 -> STOP.
// - STOP: sample on the tick where sample_cnt==15.
//   High: good frame. Low: frame_error=1; rx_data and rx_data_ready unchanged. Either way -> IDLE.
// - Good frame completion, outputs valid the cycle after the stop-sample tick:
//   - rx_data_ready=0 or rx_data_ack=1 that cycle: rx_data<=shift_reg, rx_data_ready=1.
//   - rx_data_ready=1 and no ack: overrun_error=1, new byte discarded, old rx_data kept.
// - Ack with no completion: rx_data_ready=0 next cycle. Ack while ready=0: no effect.
// - err_clear and a new error in the same cycle: the error wins (flag stays 1).
// - Start-to-ready latency ~ 9.5 bit times + 2-3 clk (synchronizer + register).
// CONFIGURATION
// - UART_RX_PARITY_EN defined:
//   - 9th bit in READ_DATA (bit_idx reaches 9 before STOP) is even parity over data[7:0].
//   - Adds output parity_error (sticky, 1 bit), set on mismatch at good-stop completion.
//   - Byte still loaded/handled as in the completion rules; err_clear clears it.
// - Undefined: 8N1 only. No parity_error port, no 9th bit.
// TESTING (bench params: CLK_FREQ_HZ=6_400_000, BAUD_RATE=100_000 -> TICK_DIV=4, 64 clk/bit)
// - Send 0xA5 8N1 -> rx_data=0xA5, rx_data_ready=1 ~9.5 bit times after start edge; errors=0; rx_busy low after.
// - Start glitch: line low 20 clk, then high -> FSM returns IDLE; rx_data_ready stays 0, no flags.
// - 0x3C with stop bit low -> frame_error=1, rx_data_ready=0, rx_data unchanged. err_clear -> frame_error=0.
// - 0x11 then 0x22, no ack -> rx_data=0x11, overrun_error=1. Ack -> rx_data_ready=0.
// - 0x11 then 0x22 with ack on the exact completion cycle of 0x22 -> rx_data=0x22, ready=1, overrun_error=0.
// - Assert reset_n=0 mid-bit 4 of 0xFF -> all outputs 0, FSM IDLE. Release, send 0x5A -> clean receive.
// - (UART_RX_PARITY_EN) 0x07 with parity bit 0 -> parity_error=1, rx_data=0x07; parity bit 1 -> parity_error=0.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 16x oversampled, LSB first, with sticky frame/overrun flags.
// Optional even-parity bit and parity_error output when UART_RX_PARITY_EN is defined.
module uart_receiver #(
    parameter int CLK_FREQ_HZ = 20_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_serial_in,
    input  logic       rx_data_ack,
    input  logic       err_clear,
    output logic [7:0] rx_data,
    output logic       rx_data_ready,
    output logic       rx_busy,
    output logic       frame_error,
    output logic       overrun_error,
`ifdef UART_RX_PARITY_EN
    output logic       parity_error,
`endif
    output logic [1:0] rx_state_o
);

    localparam int TICK_DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SMP_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
`ifdef UART_RX_PARITY_EN
    localparam int NUM_BITS = 9;
`else
    localparam int NUM_BITS = 8;
`endif
    localparam logic [SMP_W-1:0]  MID_CNT  = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0]  BIT_CNT  = SMP_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        LAST_IDX = 4'(NUM_BITS - 1);
    localparam logic [TICK_W-1:0] TICK_TOP = TICK_W'(TICK_DIV - 1);

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("uart_receiver: CLK_FREQ_HZ too low for BAUD_RATE*OVERSAMPLE (TICK_DIV < 1)");
    end

    typedef enum logic [1:0] {
        S_UART_RX_IDLE           = 2'd0,
        S_UART_RX_VALIDATE_START = 2'd1,
        S_UART_RX_READ_DATA      = 2'd2,
        S_UART_RX_STOP           = 2'd3
    } uart_fsm_state_t;

    uart_fsm_state_t   state_q;
    logic              sync1_q, sync2_q, prev_q;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic              fall_edge;
    logic [SMP_W-1:0]  sample_cnt_q;
    logic [3:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic [7:0]        rx_data_q;
    logic              rx_data_ready_q;
    logic              frame_error_q;
    logic              overrun_error_q;
`ifdef UART_RX_PARITY_EN
    logic              parity_bit_q;
    logic              parity_error_q;
`endif

    // Two-flop synchronizer plus one extra stage holding the previous synced value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_serial_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_edge = prev_q & ~sync2_q;

    always_comb begin
        tick       = (tick_cnt_q == TICK_TOP);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Handshake: rx_data_ready is the valid; rx_data_ack is a one-cycle ready/consume
    // strobe. A byte completing in the ack cycle replaces the consumed one without overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_UART_RX_IDLE;
            sample_cnt_q    <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            rx_data_q       <= '0;
            rx_data_ready_q <= 1'b0;
            frame_error_q   <= 1'b0;
            overrun_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q    <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            if (rx_data_ack) begin
                rx_data_ready_q <= 1'b0;
            end
            // Later assignments below take precedence, so a same-cycle error wins over clear.
            if (err_clear) begin
                frame_error_q   <= 1'b0;
                overrun_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_error_q  <= 1'b0;
`endif
            end

            case (state_q)
                S_UART_RX_IDLE: begin
                    if (fall_edge) begin
                        state_q      <= S_UART_RX_VALIDATE_START;
                        sample_cnt_q <= '0;
                    end
                end

                S_UART_RX_VALIDATE_START: begin
                    if (tick) begin
                        if (sample_cnt_q == MID_CNT) begin
                            sample_cnt_q <= '0;
                            bit_idx_q    <= '0;
                            state_q      <= sync2_q ? S_UART_RX_IDLE : S_UART_RX_READ_DATA;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + SMP_W'(1);
                        end
                    end
                end

                S_UART_RX_READ_DATA: begin
                    if (tick) begin
                        if (sample_cnt_q == BIT_CNT) begin
                            sample_cnt_q <= '0;
                            bit_idx_q    <= bit_idx_q + 4'd1;
`ifdef UART_RX_PARITY_EN
                            if (bit_idx_q == 4'd8) begin
                                parity_bit_q <= sync2_q;
                            end else begin
                                shift_q <= {sync2_q, shift_q[7:1]};
                            end
`else
                            shift_q <= {sync2_q, shift_q[7:1]};
`endif
                            if (bit_idx_q == LAST_IDX) begin
                                state_q <= S_UART_RX_STOP;
                            end
                        end else begin
                            sample_cnt_q <= sample_cnt_q + SMP_W'(1);
                        end
                    end
                end

                S_UART_RX_STOP: begin
                    if (tick) begin
                        if (sample_cnt_q == BIT_CNT) begin
                            sample_cnt_q <= '0;
                            state_q      <= S_UART_RX_IDLE;
                            if (sync2_q) begin
                                if (!rx_data_ready_q || rx_data_ack) begin
                                    rx_data_q       <= shift_q;
                                    rx_data_ready_q <= 1'b1;
                                end else begin
                                    overrun_error_q <= 1'b1;
                                end
`ifdef UART_RX_PARITY_EN
                                if (parity_bit_q != ^shift_q) begin
                                    parity_error_q <= 1'b1;
                                end
`endif
                            end else begin
                                frame_error_q <= 1'b1;
                            end
                        end else begin
                            sample_cnt_q <= sample_cnt_q + SMP_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= S_UART_RX_IDLE;
                end
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_ready = rx_data_ready_q;
    assign rx_busy       = (state_q != S_UART_RX_IDLE);
    assign frame_error   = frame_error_q;
    assign overrun_error = overrun_error_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_error_q;
`endif
    assign rx_state_o    = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 64 clk/bit (TICK_DIV=4).
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_receiver;

    localparam int         BIT_CLKS = 64;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_serial_in;
    logic       rx_data_ack;
    logic       err_clear;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_busy;
    logic       frame_error;
    logic       overrun_error;
    logic [1:0] rx_state_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    uart_receiver #(
        .CLK_FREQ_HZ(6_400_000),
        .BAUD_RATE  (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_serial_in (rx_serial_in),
        .rx_data_ack  (rx_data_ack),
        .err_clear    (err_clear),
        .rx_data      (rx_data),
        .rx_data_ready(rx_data_ready),
        .rx_busy      (rx_busy),
        .frame_error  (frame_error),
        .overrun_error(overrun_error),
`ifdef UART_RX_PARITY_EN
        .parity_error (parity_error),
`endif
        .rx_state_o   (rx_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx_serial_in = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input bit expect_load);
        if (expect_load) exp_q.push_back(data);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^data);
`endif
        drive_bit(stop_bit);
        rx_serial_in = 1'b1;
        wait_clks(4);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] data, input logic par_bit);
        exp_q.push_back(data);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(par_bit);
        drive_bit(1'b1);
        wait_clks(4);
    endtask
`endif

    task automatic pulse_ack();
        @(negedge clk);
        rx_data_ack = 1'b1;
        @(negedge clk);
        rx_data_ack = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    // scoreboard: a new byte shows up as a ready rise or a data change while ready stays high
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (reset_n && rx_data_ready && (!prev_ready || rx_data != prev_data)) begin
            if (exp_q.size() == 0) check("sb_unexpected_byte", {24'h0, rx_data}, 32'hffff_ffff);
            else check("sb_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        end
        prev_ready <= rx_data_ready;
        prev_data  <= rx_data;
    end

    initial begin
        int lat;
        int cnt;
        logic [7:0] rnd;

        reset_n      = 1'b0;
        rx_serial_in = 1'b1;
        rx_data_ack  = 1'b0;
        err_clear    = 1'b0;
        wait_clks(5);
        check("rst_data", {24'h0, rx_data}, 32'h0);
        check("rst_ready", {31'h0, rx_data_ready}, 32'h0);
        check("rst_busy", {31'h0, rx_busy}, 32'h0);
        check("rst_flags", {30'h0, frame_error, overrun_error}, 32'h0);
        check("rst_state", {30'h0, rx_state_o}, {30'h0, ST_IDLE});
        reset_n = 1'b1;
        wait_clks(10);

        // 0xA5 with start-to-ready latency around 9.5 bit times
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                while (!rx_data_ready && lat < 800) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("a5_latency_window", {31'h0, (lat >= 600 && lat <= 620)}, 32'h1);
        check("a5_data", {24'h0, rx_data}, 32'hA5);
        check("a5_ready", {31'h0, rx_data_ready}, 32'h1);
        check("a5_flags", {30'h0, frame_error, overrun_error}, 32'h0);
        check("a5_busy_after", {31'h0, rx_busy}, 32'h0);
        pulse_ack();
        check("a5_ack_clears", {31'h0, rx_data_ready}, 32'h0);
        pulse_ack();
        check("ack_idle_noeffect", {31'h0, rx_data_ready}, 32'h0);

        // start glitch
        rx_serial_in = 1'b0;
        wait_clks(10);
        check("glitch_busy", {31'h0, rx_busy}, 32'h1);
        wait_clks(10);
        rx_serial_in = 1'b1;
        wait_clks(60);
        check("glitch_state", {30'h0, rx_state_o}, {30'h0, ST_IDLE});
        check("glitch_ready", {31'h0, rx_data_ready}, 32'h0);
        check("glitch_flags", {30'h0, frame_error, overrun_error}, 32'h0);

        // framing error
        send_frame(8'h3C, 1'b0, 1'b0);
        check("fe_flag", {31'h0, frame_error}, 32'h1);
        check("fe_ready", {31'h0, rx_data_ready}, 32'h0);
        check("fe_data_kept", {24'h0, rx_data}, 32'hA5);
        pulse_clear();
        check("fe_cleared", {31'h0, frame_error}, 32'h0);

        // overrun
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0);
        check("ovr_data_kept", {24'h0, rx_data}, 32'h11);
        check("ovr_flag", {31'h0, overrun_error}, 32'h1);
        pulse_ack();
        check("ovr_ack_ready", {31'h0, rx_data_ready}, 32'h0);
        pulse_clear();
        check("ovr_cleared", {31'h0, overrun_error}, 32'h0);

        // ack coincides with completion of the second byte
        send_frame(8'h11, 1'b1, 1'b1);
        cnt = 0;
        fork
            send_frame(8'h22, 1'b1, 1'b1);
            begin
                while (rx_state_o != ST_STOP && cnt < 2000) begin
                    @(negedge clk);
                    cnt++;
                end
                repeat (63) @(posedge clk);
                @(negedge clk);
                rx_data_ack = 1'b1;
                @(negedge clk);
                rx_data_ack = 1'b0;
            end
        join
        check("ackc_stop_seen", {31'h0, (cnt < 2000)}, 32'h1);
        check("ackc_data", {24'h0, rx_data}, 32'h22);
        check("ackc_ready", {31'h0, rx_data_ready}, 32'h1);
        check("ackc_no_overrun", {31'h0, overrun_error}, 32'h0);

        // reset mid bit 4 of 0xFF, ready still set from the previous byte
        rx_serial_in = 1'b0;
        wait_clks(BIT_CLKS);
        rx_serial_in = 1'b1;
        wait_clks(BIT_CLKS * 4 + 32);
        check("midrst_busy_before", {31'h0, rx_busy}, 32'h1);
        reset_n = 1'b0;
        wait_clks(2);
        check("midrst_data", {24'h0, rx_data}, 32'h0);
        check("midrst_ready", {31'h0, rx_data_ready}, 32'h0);
        check("midrst_busy", {31'h0, rx_busy}, 32'h0);
        check("midrst_state", {30'h0, rx_state_o}, {30'h0, ST_IDLE});
        reset_n = 1'b1;
        wait_clks(10);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("post_rst_data", {24'h0, rx_data}, 32'h5A);
        check("post_rst_flags", {30'h0, frame_error, overrun_error}, 32'h0);
        pulse_ack();

        // random bytes, acked between frames
        for (int i = 0; i < 4; i++) begin
            rnd = 8'($urandom_range(0, 255));
            send_frame(rnd, 1'b1, 1'b1);
            check("rnd_ready", {31'h0, rx_data_ready}, 32'h1);
            pulse_ack();
        end

`ifdef UART_RX_PARITY_EN
        send_frame_par(8'h07, 1'b0);
        check("par_bad_flag", {31'h0, parity_error}, 32'h1);
        check("par_bad_data", {24'h0, rx_data}, 32'h07);
        pulse_ack();
        pulse_clear();
        check("par_cleared", {31'h0, parity_error}, 32'h0);
        send_frame_par(8'h07, 1'b1);
        check("par_good_flag", {31'h0, parity_error}, 32'h0);
        pulse_ack();
`endif

        wait_clks(4);
        check("sb_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
